bht_predictor: RTL

- Parametrised branch history table (BHT) for the pipelined RISC-V core.
- Holds 2^IDX_BITS saturating direction counters, indexed by fetch-PC bits, in place of the single global 2-bit counter.
- Fetch stage queries it for each branch; the EX/MEM stage writes back the resolved outcome.
- Also keeps branch and mispredict statistics counters.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/bht_predictor_if.sv | 28 ++
 rtl/bp_sat_counter.sv | 42 ++++
 rtl/bht_predictor.sv | 95 +++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: default widths, the counter
// reset value and saturating step helpers used by the counters and statistics.
package bp_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int CTR_BITS_DEF = 2;

    // Weakly-taken starting value: only the counter MSB set.
    function automatic int ctr_init(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    // Increment that holds at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

    // Decrement that holds at zero instead of wrapping.
    function automatic logic [31:0] sat_dec(input logic [31:0] val);
        return (val == 32'd0) ? val : val - 32'd1;
    endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Fetch-query, resolve-update and statistics signals between the core
// (master) and the branch history table (slave).
interface bht_predictor_if #(
    parameter int XLEN      = 32,
    parameter int IDX_BITS  = 4,
    parameter int STAT_BITS = 16
);
    logic                 pred_valid;
    logic [XLEN-1:0]      pred_pc;
    logic                 pred_taken;
    logic [IDX_BITS-1:0]  pred_idx;
    logic                 upd_valid;
    logic [IDX_BITS-1:0]  upd_idx;
    logic                 upd_taken;
    logic                 upd_pred;
    logic [STAT_BITS-1:0] stat_branches;
    logic [STAT_BITS-1:0] stat_mispredicts;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        input  pred_taken, pred_idx, stat_branches, stat_mispredicts
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        output pred_taken, pred_idx, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/bp_sat_counter.sv
// One saturating direction counter. o_next is the value the counter will
// take at the next edge, so the top can forward a same-cycle update.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_BITS = CTR_BITS_DEF,
    parameter int INIT     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [CTR_BITS-1:0] o_ctr,
    output logic [CTR_BITS-1:0] o_next
);
    localparam logic [31:0] CTR_MAX = 32'((64'd1 << CTR_BITS) - 64'd1);

    logic [CTR_BITS-1:0] r_ctr;
    logic [CTR_BITS-1:0] w_next;

    // Next value: saturating step in the requested direction, else hold.
    always_comb begin
        w_next = r_ctr;
        if (i_inc) begin
            w_next = CTR_BITS'(sat_inc(32'(r_ctr), CTR_MAX));
        end else if (i_dec) begin
            w_next = CTR_BITS'(sat_dec(32'(r_ctr)));
        end
    end

    // Counter register; reset overrides any pending step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr <= CTR_BITS'(INIT);
        end else begin
            r_ctr <= w_next;
        end
    end

    assign o_ctr  = r_ctr;
    assign o_next = w_next;
endmodule

// File: rtl/bht_predictor.sv
// Branch history table: 2^IDX_BITS saturating direction counters indexed by
// fetch-PC bits, combinational prediction with write-through forwarding of a
// same-cycle update, and saturating branch/mispredict statistics.
// Optional gshare indexing (global history XORed into the index) is enabled
// by defining BHT_GSHARE_EN.
module bht_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int IDX_BITS  = 4,
    parameter int CTR_BITS  = CTR_BITS_DEF,
    parameter int PC_LSB    = 2,
    parameter int STAT_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    bht_predictor_if.slave   bp
);
    localparam int          DEPTH    = 1 << IDX_BITS;
    localparam int          INIT     = ctr_init(CTR_BITS);
    localparam logic [31:0] STAT_MAX = 32'((64'd1 << STAT_BITS) - 64'd1);

    logic [CTR_BITS-1:0]  w_ctr  [DEPTH];
    logic [CTR_BITS-1:0]  w_next [DEPTH];
    logic [IDX_BITS-1:0]  w_pc_idx;
    logic [IDX_BITS-1:0]  w_pred_idx;
    logic                 w_bypass;
    logic [CTR_BITS-1:0]  w_sel_ctr;
    logic [STAT_BITS-1:0] r_branches;
    logic [STAT_BITS-1:0] r_mispredicts;
    logic                 w_unused_pc;

    assign w_pc_idx    = bp.pred_pc[PC_LSB+IDX_BITS-1:PC_LSB];
    assign w_unused_pc = ^bp.pred_pc;

`ifdef BHT_GSHARE_EN
    logic [IDX_BITS-1:0] r_ghr;

    // Global history shifts in each resolved outcome alongside the counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (bp.upd_valid) begin
            r_ghr <= IDX_BITS'({r_ghr, bp.upd_taken});
        end
    end

    assign w_pred_idx = w_pc_idx ^ r_ghr;
`else
    assign w_pred_idx = w_pc_idx;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic w_hit;
        assign w_hit = bp.upd_valid && (bp.upd_idx == IDX_BITS'(g));

        bp_sat_counter #(
            .CTR_BITS (CTR_BITS),
            .INIT     (INIT)
        ) u_ctr (
            .clk    (clk),
            .rst    (rst),
            .i_inc  (w_hit && bp.upd_taken),
            .i_dec  (w_hit && !bp.upd_taken),
            .o_ctr  (w_ctr[g]),
            .o_next (w_next[g])
        );
    end

    // Prediction: read the indexed counter, forwarding the post-update value
    // when the resolving branch writes the same entry this cycle.
    always_comb begin
        w_bypass  = bp.upd_valid && (bp.upd_idx == w_pred_idx);
        w_sel_ctr = w_bypass ? w_next[w_pred_idx] : w_ctr[w_pred_idx];
    end

    assign bp.pred_idx   = w_pred_idx;
    assign bp.pred_taken = bp.pred_valid & w_sel_ctr[CTR_BITS-1];

    // Statistics: count resolved branches and mispredicts, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else if (bp.upd_valid) begin
            r_branches <= STAT_BITS'(sat_inc(32'(r_branches), STAT_MAX));
            if (bp.upd_pred != bp.upd_taken) begin
                r_mispredicts <= STAT_BITS'(sat_inc(32'(r_mispredicts), STAT_MAX));
            end
        end
    end

    assign bp.stat_branches    = r_branches;
    assign bp.stat_mispredicts = r_mispredicts;
endmodule
